// File: rtl/mliu_arbiter_pkg.sv
// Shared types for the ML inference unit request/response interface and the
// requester arbiter that multiplexes several issuers onto one unit.
package mliu_arbiter_pkg;

    localparam int MLIU_DATA_W              = 32;
    localparam int MLIU_ARB_NUM_REQ         = 4;
    localparam int MLIU_ARB_MAX_OUTSTANDING = 4;
    localparam int MLIU_ARB_ID_W            = $clog2(MLIU_ARB_NUM_REQ);

    typedef enum logic [1:0] {
        MLIU_RELU     = 2'd0,
        MLIU_AVG_POOL = 2'd1,
        MLIU_MAX_POOL = 2'd2,
        MLIU_MAC      = 2'd3
    } mliu_op_e;

    typedef struct packed {
        logic                   valid;
        mliu_op_e               op;
        logic [MLIU_DATA_W-1:0] operand1;
        logic [MLIU_DATA_W-1:0] operand2;
    } mliu_req_t;

    typedef struct packed {
        logic                   valid;
        logic [MLIU_DATA_W-1:0] data;
        logic                   error;
    } mliu_rsp_t;

    typedef logic [MLIU_ARB_ID_W-1:0] mliu_arb_id_t;

    typedef struct packed {
        mliu_arb_id_t id;
        mliu_rsp_t    rsp;
    } mliu_arb_rsp_entry_t;

    function automatic int mliuArbNext(input int idx, input int numReq);
        return (idx + 1 >= numReq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mliu_arb_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may coincide,
// including when full (slot freed by the pop) or empty (only the push lands).
module mliu_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign doPop   = pop_i & ~empty_o;
    assign doPush  = push_i & (~full_o | doPop);

    always_comb begin
        wrPtr_d = doPush ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = doPop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!doPush && doPop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing reads a slot before it has been written.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mliu_arbiter.sv
// Round-robin arbiter sharing one non-stallable ML inference unit between
// several requesters, with credit-limited issue and per-requester response routing.
module mliu_arbiter
    import mliu_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = MLIU_ARB_NUM_REQ,
    parameter int MAX_OUTSTANDING = MLIU_ARB_MAX_OUTSTANDING,
    parameter int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  mliu_req_t                          req_i [NUM_REQ],
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output mliu_rsp_t                          rsp_o [NUM_REQ],
    input  logic [NUM_REQ-1:0]                 rsp_ready_i,
    output mliu_req_t                          mliu_req_o,
    input  logic                               mliu_req_ready_i,
    input  mliu_rsp_t                          mliu_rsp_i,
    output logic                               mliu_rsp_ready_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        mliu_rsp_t       rsp;
    } entry_t;

    logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [ID_W-1:0]  candIdx;
    logic [ID_W-1:0]  winIdx;
    logic             anyValid;
    logic             creditOk;
    logic             fire;

    logic [ID_W-1:0]  idHead;
    logic             idEmpty, idFull;
    logic [CNT_W-1:0] idCount;
    logic             idPop;

    entry_t           rspEntry;
    entry_t           rspHead;
    logic             rspEmpty, rspFull;
    logic [CNT_W-1:0] rspCount;
    logic             rspPop;

    logic             unused_fifoStatus;

    assign creditOk = (count_q < CNT_W'(MAX_OUTSTANDING));

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        anyValid = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            candIdx = ID_W'((int'(rrPtr_q) + i) % NUM_REQ);
            if (!anyValid && req_i[candIdx].valid) begin
                anyValid = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // Outputs are held at zero while reset is asserted, whatever the requesters drive.
    always_comb begin
        mliu_req_o  = '0;
        req_ready_o = '0;
        if (rst_ni && anyValid && creditOk) begin
            mliu_req_o          = req_i[winIdx];
            req_ready_o[winIdx] = mliu_req_ready_i;
        end
    end

    assign fire   = mliu_req_o.valid & mliu_req_ready_i;
    assign idPop  = mliu_rsp_i.valid & ~idEmpty;
    assign rspPop = ~rspEmpty & rsp_ready_i[rspHead.id];

    assign rspEntry.id  = idHead;
    assign rspEntry.rsp = mliu_rsp_i;

    always_comb begin
        rrPtr_d = fire ? ID_W'(mliuArbNext(int'(winIdx), NUM_REQ)) : rrPtr_q;
        err_d   = err_q | (mliu_rsp_i.valid & idEmpty);
        count_d = count_q;
        if (fire && !rspPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!fire && rspPop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rrPtr_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rrPtr_q <= rrPtr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    mliu_arb_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_idFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fire),
        .wdata_i (winIdx),
        .pop_i   (idPop),
        .rdata_o (idHead),
        .full_o  (idFull),
        .empty_o (idEmpty),
        .count_o (idCount)
    );

    // Credits bound the total in flight, so this FIFO cannot overflow.
    mliu_arb_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rspFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (idPop),
        .wdata_i (rspEntry),
        .pop_i   (rspPop),
        .rdata_o (rspHead),
        .full_o  (rspFull),
        .empty_o (rspEmpty),
        .count_o (rspCount)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_o[i] = '0;
            if (!rspEmpty && rspHead.id == ID_W'(i)) begin
                rsp_o[i] = rspHead.rsp;
            end
        end
    end

    assign unused_fifoStatus = ^{idFull, idCount, rspFull, rspCount};

    assign mliu_rsp_ready_o = 1'b1;
    assign outstanding_o    = count_q;
    assign busy_o           = (count_q != '0);
    assign err_o            = err_q;

endmodule
